// File: rtl/subadc_be_pkg.sv
// Shared sizing and weight helpers for the SAR sub-ADC back-end.
// Build option SUBADC_BE_AVG_EN is consumed by subadc_backend.
package subadc_be_pkg;

  localparam int DEF_ADC_BITS    = 8;
  localparam int DEF_WEIGHT_BITS = 10;
  // Upper bounds for the generic slice helper.
  localparam int WVEC_MAX = 1024;
  localparam int WMAX     = 32;

  function automatic int out_bits(input int weight_bits, input int adc_bits);
    return weight_bits + $clog2(adc_bits);
  endfunction

  // Binary weights with 2 fractional bits: weight_i = 4 << i.
  function automatic logic [DEF_ADC_BITS*DEF_WEIGHT_BITS-1:0] default_weights();
    logic [DEF_ADC_BITS*DEF_WEIGHT_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < DEF_ADC_BITS; i++)
      v[i*DEF_WEIGHT_BITS +: DEF_WEIGHT_BITS] = DEF_WEIGHT_BITS'(4 << i);
    return v;
  endfunction

  function automatic logic [WMAX-1:0] weight_slice(input logic [WVEC_MAX-1:0] vec,
                                                   input int idx, input int wb);
    logic [WMAX-1:0] mask;
    mask = (WMAX'(1) << wb) - WMAX'(1);
    return WMAX'(vec >> (idx * wb)) & mask;
  endfunction

endpackage

// File: rtl/subadc_be_fifo.sv
// Small synchronous FIFO; dout holds the last popped word while empty,
// and a push into a full FIFO without a same-cycle pop is dropped.
module subadc_be_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wp, rp;
  logic [W-1:0]            last_q;
  logic                    pop_ok, push_ok;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign dout    = empty ? last_q : mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp     <= '0;
      rp     <= '0;
      last_q <= '0;
    end else begin
      if (pop_ok) begin
        last_q <= mem[rp[AW-1:0]];
        rp     <= rp + 1'b1;
      end
      if (push_ok) wp <= wp + 1'b1;
    end
  end

  // Storage needs no reset: it is only observable through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/subadc_backend.sv
// SAR sub-ADC back-end: compl sync, weighted sum, saturating offset, output FIFO.
// Define SUBADC_BE_AVG_EN to build the windowed averager on avg_data/avg_valid.
module subadc_backend import subadc_be_pkg::*; #(
  parameter  int ADC_BITS    = 8,
  parameter  int WEIGHT_BITS = 10,
  parameter  int OFFSET_BITS = 12,
  parameter  int FIFO_DEPTH  = 4,
  parameter  int AVG_LOG2    = 4,
  localparam int OUT_BITS    = out_bits(WEIGHT_BITS, ADC_BITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [ADC_BITS-1:0]           subadc_data,
  input  logic                          subadc_compl,
  input  logic [ADC_BITS*WEIGHT_BITS-1:0] weights,
  input  logic [OFFSET_BITS-1:0]        offset,
  output logic [OUT_BITS-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [15:0]                   conv_cnt,
  output logic [OUT_BITS-1:0]           avg_data,
  output logic                          avg_valid
);

  localparam int STAGES = 1;
  // Wide enough for sum minus a sign-extended offset without wrap.
  localparam int DW = ((OUT_BITS > OFFSET_BITS) ? OUT_BITS : OFFSET_BITS) + 2;

  logic                          s1, s2, s3, cap;
  logic [STAGES:0]               vld_pipe;
  logic [ADC_BITS-1:0]           data_q;
  logic [ADC_BITS-1:0][OUT_BITS-1:0] term;
  logic [OUT_BITS-1:0]           sum_c, sum_q, corr;
  logic [DW-1:0]                 diff;
  logic                          fifo_full, fifo_empty, fifo_drop;

  assign cap = s2 & ~s3 & en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s3, s2, s1} <= '0;
      vld_pipe     <= '0;
      data_q       <= '0;
      sum_q        <= '0;
      conv_cnt     <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, subadc_compl};
      vld_pipe     <= {vld_pipe[STAGES-1:0], cap};
      if (cap) begin
        data_q   <= subadc_data;
        conv_cnt <= conv_cnt + 16'd1;
      end
      if (vld_pipe[0]) sum_q <= sum_c;
    end
  end

  for (genvar i = 0; i < ADC_BITS; i++) begin : g_term
    assign term[i] = data_q[i]
      ? OUT_BITS'(weight_slice(WVEC_MAX'(weights), i, WEIGHT_BITS)) : '0;
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < ADC_BITS; i++) sum_c = sum_c + term[i];
  end

  assign diff = {{(DW-OUT_BITS){1'b0}}, sum_q}
              - {{(DW-OFFSET_BITS){offset[OFFSET_BITS-1]}}, offset};

  always_comb begin
    corr = diff[OUT_BITS-1:0];
    if (diff[DW-1])                  corr = '0;
    else if (|diff[DW-2:OUT_BITS])   corr = '1;
  end

  subadc_be_fifo #(.W(OUT_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[STAGES]),
    .din   (corr),
    .pop   (out_ready),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign out_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ovf <= 1'b0;
    else if (fifo_drop & fifo_full) ovf <= 1'b1;
    else if (ovf_clr)              ovf <= 1'b0;
  end

`ifdef SUBADC_BE_AVG_EN
  logic [OUT_BITS+AVG_LOG2-1:0] acc, acc_nxt;
  logic [AVG_LOG2-1:0]          avg_cnt;

  // Every corrected sample counts, including ones the FIFO drops.
  assign acc_nxt = acc + (OUT_BITS+AVG_LOG2)'(corr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      avg_cnt   <= '0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (vld_pipe[STAGES]) begin
        avg_cnt <= avg_cnt + 1'b1;
        if (&avg_cnt) begin
          avg_data  <= acc_nxt[OUT_BITS+AVG_LOG2-1:AVG_LOG2];
          avg_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_nxt;
        end
      end
    end
  end
`else
  assign avg_data  = '0;
  assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_subadc_backend.sv
// Directed bench for subadc_backend: latency, saturation, FIFO overflow, reset, enable.
module tb_subadc_backend;
  import subadc_be_pkg::*;

`ifdef SUBADC_BE_AVG_EN
  localparam int TB_AVG = 2;
`else
  localparam int TB_AVG = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic [7:0]  subadc_data = '0;
  logic        subadc_compl = 1'b0;
  logic [79:0] weights = default_weights();
  logic [11:0] offset = '0;
  logic [12:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf;
  logic        ovf_clr = 1'b0;
  logic [15:0] conv_cnt;
  logic [12:0] avg_data;
  logic        avg_valid;

  int n_chk = 0;
  int n_fail = 0;
  int avg_pulses = 0;

  always #5 clk = ~clk;

  subadc_backend #(.ADC_BITS(8), .WEIGHT_BITS(10), .OFFSET_BITS(12),
                   .FIFO_DEPTH(4), .AVG_LOG2(TB_AVG)) dut (
    .clk(clk), .rst(rst), .en(en), .subadc_data(subadc_data),
    .subadc_compl(subadc_compl), .weights(weights), .offset(offset),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr), .conv_cnt(conv_cnt),
    .avg_data(avg_data), .avg_valid(avg_valid)
  );

  always @(negedge clk) if (avg_valid) avg_pulses++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // compl high for 3 sampling edges, then low long enough to drain the pipeline.
  task automatic conv(input logic [7:0] d);
    @(negedge clk);
    subadc_data  = d;
    subadc_compl = 1'b1;
    repeat (3) @(negedge clk);
    subadc_compl = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", conv_cnt, 0);
    chk("rst_avg", avg_data, 0);
    chk("rst_avgv", avg_valid, 0);
    rst = 1'b1;

    // Latency: first high sample at edge 1, valid visible after edge 5.
    @(negedge clk);
    subadc_data  = 8'hA5;
    subadc_compl = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) subadc_compl = 1'b0;
      if (k >= 4) chk($sformatf("lat_valid_e%0d", k), out_valid, (k == 5) ? 1 : 0);
    end
    chk("a5_data", out_data, 660);
    chk("a5_cnt", conv_cnt, 1);
    repeat (2) @(negedge clk);
    pop();
    chk("pop_empty", out_valid, 0);
    chk("pop_hold", out_data, 660);

    offset = 12'd20;
    conv(8'hA5);
    chk("off20", out_data, 640);
    pop();

    offset = 12'd5;
    conv(8'h00);
    chk("lo_sat_valid", out_valid, 1);
    chk("lo_sat", out_data, 0);
    pop();

    weights = {8{10'd1023}};
    offset  = 12'hFF6;
    conv(8'hFF);
    chk("hi_sat", out_data, 8191);
    pop();
    weights = default_weights();
    offset  = '0;

    // Overflow: 5 writes into 4 entries with no reads.
    rst_pulse();
    for (int i = 1; i <= 5; i++) conv(8'(i));
    chk("ovf_set", ovf, 1);
    chk("ovf_cnt", conv_cnt, 5);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d", i), out_data, 4 * (i + 1));
      pop();
    end
    chk("drain_empty", out_valid, 0);

    // Reset while a captured sample is still in the pipeline.
    @(negedge clk);
    subadc_data  = 8'hA5;
    subadc_compl = 1'b1;
    repeat (3) @(negedge clk);
    subadc_compl = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_cnt", conv_cnt, 0);
    chk("midrst_ovf", ovf, 0);
    conv(8'hA5);
    chk("post_rst_data", out_data, 660);
    chk("post_rst_cnt", conv_cnt, 1);
    pop();

    en = 1'b0;
    conv(8'hA5);
    en = 1'b1;
    chk("en0_cnt", conv_cnt, 1);
    chk("en0_valid", out_valid, 0);

`ifdef SUBADC_BE_AVG_EN
    rst_pulse();
    out_ready = 1'b1;
    p0 = avg_pulses;
    offset = 12'd0;   conv(8'd25);
    offset = 12'hFFE; conv(8'd25);
    offset = 12'd0;   conv(8'd26);
    offset = 12'hFFE; conv(8'd26);
    out_ready = 1'b0;
    offset = 12'd0;
    chk("avg_data", avg_data, 103);
    chk("avg_pulses", avg_pulses - p0, 1);
`else
    p0 = avg_pulses;
    chk("avg_off_pulses", p0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
